// File: rtl/dual_server_rr_scheduler.sv
// Two-channel rotating-priority scheduler: N requesters share ch0/ch1, grants held until req drops.
// Optional forced release after MAX_HOLD cycles is enabled by defining HOLD_TIMEOUT_EN.
module dual_server_rr_scheduler #(
  parameter int N        = 5,
  parameter int PW       = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt0,
  output logic [N-1:0]  gnt1,
  output logic [1:0]    busy,
  output logic [PW-1:0] ptr
`ifdef HOLD_TIMEOUT_EN
  ,
  output logic [1:0]    timeout
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ch_state_t;

  ch_state_t     st0, st1;
  logic [N-1:0]  cand, blocked;
  logic [PW-1:0] c1, c2, idx1, last, nxt_ptr;
  logic          c1_vld, c2_vld;
  logic          assign0, assign1, rel0, rel1, to0, to1;
  int            idx;

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign cand = req & ~(gnt0 | gnt1) & ~blocked;

  // Circular scan of the candidate set from ptr: first and second hits
  always_comb begin
    c1     = '0;
    c2     = '0;
    c1_vld = 1'b0;
    c2_vld = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i;
      if (cand[idx] && !c1_vld) begin
        c1_vld = 1'b1;
        c1     = idx[PW-1:0];
      end else if (cand[idx] && !c2_vld) begin
        c2_vld = 1'b1;
        c2     = idx[PW-1:0];
      end else begin
        c2_vld = c2_vld;
      end
    end
  end

  // Channel assignment, release and next-pointer decisions
  always_comb begin
    assign0 = en && (st0 == IDLE) && c1_vld;
    assign1 = en && (st1 == IDLE) && ((st0 == IDLE) ? c2_vld : c1_vld);
    idx1    = (st0 == IDLE) ? c2 : c1;
    last    = assign1 ? idx1 : c1;
    nxt_ptr = (int'(last) == N - 1) ? '0 : last + PW'(1);
    // A timed-out owner is released even though its request is still high
    rel0    = (st0 == BUSY) && (!(|(gnt0 & req)) || to0);
    rel1    = (st1 == BUSY) && (!(|(gnt1 & req)) || to1);
  end

  // Per-channel IDLE/BUSY state machines with registered grants, busy and pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0  <= IDLE;
      st1  <= IDLE;
      gnt0 <= '0;
      gnt1 <= '0;
      busy <= 2'b00;
      ptr  <= '0;
    end else begin
      case (st0)
        IDLE: begin
          if (assign0) begin
            st0     <= BUSY;
            gnt0    <= onehot(c1);
            busy[0] <= 1'b1;
          end
        end
        BUSY: begin
          if (rel0) begin
            st0     <= IDLE;
            gnt0    <= '0;
            busy[0] <= 1'b0;
          end
        end
        default: begin
          st0     <= IDLE;
          gnt0    <= '0;
          busy[0] <= 1'b0;
        end
      endcase
      case (st1)
        IDLE: begin
          if (assign1) begin
            st1     <= BUSY;
            gnt1    <= onehot(idx1);
            busy[1] <= 1'b1;
          end
        end
        BUSY: begin
          if (rel1) begin
            st1     <= IDLE;
            gnt1    <= '0;
            busy[1] <= 1'b0;
          end
        end
        default: begin
          st1     <= IDLE;
          gnt1    <= '0;
          busy[1] <= 1'b0;
        end
      endcase
      if (assign0 || assign1) begin
        ptr <= nxt_ptr;
      end
    end
  end

`ifdef HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hold0, hold1;

  assign to0 = (st0 == BUSY) && (|(gnt0 & req)) && (hold0 == HW'(MAX_HOLD - 1));
  assign to1 = (st1 == BUSY) && (|(gnt1 & req)) && (hold1 == HW'(MAX_HOLD - 1));

  // Hold counters, timeout pulses and the block mask that keeps a timed-out owner out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0   <= '0;
      hold1   <= '0;
      blocked <= '0;
      timeout <= 2'b00;
    end else begin
      hold0   <= (st0 == BUSY) ? hold0 + HW'(1) : '0;
      hold1   <= (st1 == BUSY) ? hold1 + HW'(1) : '0;
      blocked <= (blocked & req) | (to0 ? gnt0 : '0) | (to1 ? gnt1 : '0);
      timeout <= {to1, to0};
    end
  end
`else
  assign blocked = '0;
  assign to0     = 1'b0;
  assign to1     = 1'b0;
`endif

endmodule

// File: tb/tb_dual_server_rr_scheduler.sv
// Directed scoreboard bench for dual_server_rr_scheduler (N=5); timeout steps run with HOLD_TIMEOUT_EN.
module tb_dual_server_rr_scheduler;

  localparam int N        = 5;
  localparam int PW       = $clog2(N);
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt0, gnt1;
  logic [1:0]    busy;
  logic [PW-1:0] ptr;
`ifdef HOLD_TIMEOUT_EN
  logic [1:0]    timeout;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [N-1:0]  g0;
    logic [N-1:0]  g1;
    logic [PW-1:0] p;
    logic [1:0]    to;
  } exp_t;

  exp_t         sbq[$];
  logic [N-1:0] req_prev = '0;

  dual_server_rr_scheduler #(.N(N), .PW(PW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .ptr     (ptr)
`ifdef HOLD_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, compare after the edge
  task automatic step(input string tag, input logic e, input logic [N-1:0] r,
                      input logic [N-1:0] g0, input logic [N-1:0] g1,
                      input logic [PW-1:0] p, input logic [1:0] to);
    exp_t x;
    en   = e;
    req  = r;
    x.g0 = g0;
    x.g1 = g1;
    x.p  = p;
    x.to = to;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(x.g0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(x.g1));
    chk({tag, ".busy"}, 32'(busy), 32'({|x.g1, |x.g0}));
    chk({tag, ".ptr"},  32'(ptr),  32'(x.p));
`ifdef HOLD_TIMEOUT_EN
    chk({tag, ".timeout"}, 32'(timeout), 32'(x.to));
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(0));
    chk({tag, ".busy"}, 32'(busy), 32'(0));
    chk({tag, ".ptr"},  32'(ptr),  32'(0));
  endtask

  always @(posedge clk) req_prev <= req;

  // Structural invariants sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv.onehot0_gnt0", 32'($onehot0(gnt0)), 32'(1));
      chk("inv.onehot0_gnt1", 32'($onehot0(gnt1)), 32'(1));
      chk("inv.disjoint",     32'(gnt0 & gnt1), 32'(0));
      chk("inv.gnt_in_req",   32'((gnt0 | gnt1) & ~req_prev), 32'(0));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired: observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    step("t2",    1'b1, 5'b10110, 5'b00010, 5'b00100, 3'd3, 2'b00);
    step("t3a",   1'b1, 5'b10100, 5'b00000, 5'b00100, 3'd3, 2'b00);
    step("t3b",   1'b1, 5'b10100, 5'b10000, 5'b00100, 3'd0, 2'b00);
    step("clr1",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 2'b00);
    step("p4a",   1'b1, 5'b01000, 5'b01000, 5'b00000, 3'd4, 2'b00);
    step("p4b",   1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd4, 2'b00);
    step("t4a",   1'b1, 5'b10001, 5'b10000, 5'b00001, 3'd1, 2'b00);
    step("t4b",   1'b1, 5'b00001, 5'b00000, 5'b00001, 3'd1, 2'b00);
    step("t4c",   1'b1, 5'b00001, 5'b00000, 5'b00001, 3'd1, 2'b00);
    step("clr2",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd1, 2'b00);
    step("p5a",   1'b1, 5'b00010, 5'b00010, 5'b00000, 3'd2, 2'b00);
    step("p5b",   1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step("t5off", 1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd2, 2'b00);
    end
    step("t5on",  1'b1, 5'b11111, 5'b00100, 5'b01000, 3'd4, 2'b00);

    // Asynchronous reset between edges while both channels are busy
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t1async");
    @(posedge clk);
    #1;
    chk_zero("t1held");
    rst = 1'b0;

    step("r1",    1'b1, 5'b11000, 5'b01000, 5'b10000, 3'd0, 2'b00);
    step("t5rel", 1'b0, 5'b01001, 5'b01000, 5'b00000, 3'd0, 2'b00);
    step("ch1",   1'b1, 5'b01001, 5'b01000, 5'b00001, 3'd1, 2'b00);
    step("clr3",  1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd1, 2'b00);

`ifdef HOLD_TIMEOUT_EN
    step("t6g",   1'b1, 5'b00001, 5'b00001, 5'b00000, 3'd1, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step("t6h", 1'b1, 5'b00001, 5'b00001, 5'b00000, 3'd1, 2'b00);
    end
    step("t6to",  1'b1, 5'b00001, 5'b00000, 5'b00000, 3'd1, 2'b01);
    step("t6blk", 1'b1, 5'b00001, 5'b00000, 5'b00000, 3'd1, 2'b00);
    step("t6blk", 1'b1, 5'b00001, 5'b00000, 5'b00000, 3'd1, 2'b00);
    step("t6drop",1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd1, 2'b00);
    step("t6re",  1'b1, 5'b00001, 5'b00001, 5'b00000, 3'd1, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
